bios_loader: RTL and testbench
==============================

Name: bios_loader

Overview:
- Sits between the hps_io ioctl download port and the system BIOS write port (BIOS_ADDR/BIOS_DIN/BIOS_WR/BIOS_REQ).
- Packs the downloaded byte stream into little-endian 16-bit words and buffers them in a small FIFO.
- Delivers the words to the system at the pace set by the system's request line.
- Raises bios_loaded once the full image has been written; the top level holds the CPU in reset until then.

Parameters:
- BIOS_INDEX, 8'd0, ioctl_index value that selects the BIOS image; downloads with any other index are ignored.
- BIOS_WORDS, 8192, number of 16-bit words in a complete image (16 KB).
- FIFO_DEPTH, 16, word FIFO depth; must be a power of two, minimum 4.

Ports:
- clk_sys  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download active (from hps_io).
- ioctl_index  in  8  image index of the current download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address within the image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  backpressure to hps_io.
- bios_req  in  1  system is ready to accept BIOS words.
- bios_addr  out  13  word address presented to the system.
- bios_din  out  16  word data, {odd byte, even byte}.
- bios_wr  out  1  one-cycle write strobe to the system.
- bios_loaded  out  1  complete image delivered; sticky.
- bios_err  out  1  bad download (short, out of order, or overlong); sticky.

Behaviour:
- Reset (async):
  - All outputs 0; FIFO empty; byte and word counters 0; state IDLE.
  - Reset mid-load abandons the load; the block returns to IDLE and needs a fresh download.
- Selection:
  - dl_sel = ioctl_download & (ioctl_index == BIOS_INDEX).
  - Strobes while dl_sel = 0 are ignored and do not affect ioctl_wait.
- State IDLE:
  - On the rising edge of dl_sel, go to LOAD.
  - On entry: clear FIFO, byte counter, word counter, bios_loaded and bios_err.
- State LOAD, byte packing:
  - Expected lane = byte counter bit 0.
  - On ioctl_wr with ioctl_addr[0] == expected lane: lane 0 latches the low byte; lane 1 pushes {ioctl_dout, low byte} into the FIFO.
  - Byte counter increments on every accepted byte.
  - If ioctl_addr[0] != expected lane: set bios_err and drop the byte.
  - Bytes arriving after 2*BIOS_WORDS have been accepted: drop them and set bios_err.
- Backpressure:
  - ioctl_wait = 1 while FIFO free entries <= 1 (registered), so one in-flight strobe is always absorbed.
  - A push into a full FIFO must never occur; the bench asserts this.
- Drain to system (LOAD and DRAIN states):
  - In any cycle where bios_req = 1 and the FIFO is non-empty: pop one word.
  - In the next cycle: bios_wr = 1, bios_din = popped word, bios_addr = word counter; then the word counter increments.
  - bios_addr/bios_din hold their values after bios_wr drops.
  - Maximum rate is one word per clock.
  - A simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- Falling edge of dl_sel in LOAD, go to DRAIN:
  - If a lane-0 byte is pending (odd byte count), first push {8'h00, low byte}.
  - If the byte count is < 2*BIOS_WORDS, set bios_err.
- State DRAIN:
  - Continue popping until the FIFO is empty.
  - When word counter == BIOS_WORDS: set bios_loaded and go to DONE.
  - If the FIFO is empty and word counter < BIOS_WORDS: go to DONE with bios_loaded = 0.
- State DONE:
  - bios_loaded and bios_err held.
  - A new rising edge of dl_sel restarts the load (same as the IDLE transition).
- Word counter width:
  - 14 bits, so that 8192 is representable.
  - bios_addr = counter[12:0]; the counter does not wrap during a legal load.
- Early completion: if word counter reaches BIOS_WORDS while still in LOAD, bios_loaded is still asserted immediately.

Decomposition:
- Package bios_loader_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, DONE};
  - localparams BYTE_CNT_W = $clog2(2*BIOS_WORDS)+1 and WORD_CNT_W = $clog2(BIOS_WORDS)+1.
- One sub-module, sync_word_fifo:
  - 16-bit single-clock FIFO, depth FIFO_DEPTH;
  - ports push/pop/full/empty/free_cnt; async reset plus sync clear.

Test Plan:
- Full 16384-byte download, byte k = k[7:0] ^ k[15:8], bios_req held 1:
  - 8192 bios_wr pulses, addresses 0..8191 in order;
  - word n = {byte 2n+1, byte 2n};
  - bios_loaded = 1, bios_err = 0.
- Backpressure: bios_req = 0 from byte 0 while bytes stream every cycle:
  - ioctl_wait rises after at most 2*(FIFO_DEPTH-1) accepted bytes;
  - no FIFO overflow;
  - after bios_req = 1, the words drain in order with no loss.
- Wrong index (ioctl_index = 1), 100 bytes: no bios_wr, ioctl_wait = 0, state stays IDLE.
- Short, odd download of 3 bytes AA, BB, CC:
  - writes addr0 = 16'hBBAA and addr1 = 16'h00CC;
  - bios_err = 1, bios_loaded = 0.
- Out-of-order download (ioctl_addr sequence 0, 2): bios_err = 1 and the second byte is dropped.
- Reset at word 4000 followed by a fresh full download:
  - all outputs 0 during reset;
  - the second load starts at addr 0 and completes with bios_loaded = 1.

Source files
------------

// File: rtl/bios_loader_pkg.sv
// bios_loader_pkg
//   Shared types and widths for the BIOS loader.
//   - state_e     : loader state machine encoding
//   - BIOS_WORDS_DEF / BYTE_CNT_W / WORD_CNT_W : counter widths sized so a
//     full image count (2*BIOS_WORDS bytes, BIOS_WORDS words) is representable
//   - BIOS_ADDR_W : width of the word address handed to the system
package bios_loader_pkg;

    localparam int BIOS_WORDS_DEF = 8192;
    localparam int BYTE_CNT_W     = $clog2(2 * BIOS_WORDS_DEF) + 1;
    localparam int WORD_CNT_W     = $clog2(BIOS_WORDS_DEF) + 1;
    localparam int BIOS_ADDR_W    = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bios_loader_if.sv
// bios_loader_if
//   Bundles the hps_io ioctl download port and the system BIOS write port.
//   - ioctl_download/index/wr/addr/dout : byte stream from hps_io
//   - ioctl_wait                        : backpressure back to hps_io
//   - bios_req                          : system ready for words
//   - bios_addr/din/wr                  : word write to the system
//   - bios_loaded/bios_err              : sticky status
//   modport slave  : the loader's view
//   modport master : the environment's view (hps_io + system)
interface bios_loader_if;
    import bios_loader_pkg::*;

    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic                   ioctl_wait;
    logic                   bios_req;
    logic [BIOS_ADDR_W-1:0] bios_addr;
    logic [15:0]            bios_din;
    logic                   bios_wr;
    logic                   bios_loaded;
    logic                   bios_err;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        output ioctl_wait, bios_addr, bios_din, bios_wr, bios_loaded, bios_err
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        input  ioctl_wait, bios_addr, bios_din, bios_wr, bios_loaded, bios_err
    );

endinterface

// File: rtl/sync_word_fifo.sv
// sync_word_fifo
//   Single-clock 16-bit FIFO with first-word-fall-through read data.
//   - clk, rst   : clock, asynchronous active-high reset
//   - clr        : synchronous flush (pointers back to zero)
//   - push/push_data : write one word (ignored when full)
//   - pop/pop_data   : pop_data shows the head word; pop consumes it
//   - full/empty/free_cnt : occupancy status
module sync_word_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    output logic [15:0]              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] DEPTH_W = PTR_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count;
    logic             do_push, do_pop;
    logic [15:0]      mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == DEPTH_W);
        empty    = (count == '0);
        free_cnt = DEPTH_W - count;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bios_loader.sv
// bios_loader
//   Packs the hps_io byte download into little-endian 16-bit words, buffers
//   them in a small FIFO and writes them to the system BIOS port whenever
//   the system requests. Raises bios_loaded after BIOS_WORDS words have been
//   written; bios_err flags short, out-of-order or overlong downloads.
//   - clk_sys : system clock
//   - reset   : asynchronous active-high reset
//   - bus     : bios_loader_if.slave (ioctl download port + BIOS write port)
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter logic [7:0] BIOS_INDEX = 8'd0,
    parameter int         BIOS_WORDS = BIOS_WORDS_DEF,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    bios_loader_if.slave  bus
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BYTE_CNT_W-1:0] BYTE_LIMIT = BYTE_CNT_W'(2 * BIOS_WORDS);
    localparam logic [WORD_CNT_W-1:0] WORD_LIMIT = WORD_CNT_W'(BIOS_WORDS);

    state_e                 state_q, state_d;
    logic                   dl_sel_q, dl_sel_d;
    logic                   dl_rise, dl_fall;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]             low_byte_q, low_byte_d;
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic                   pad_pending_q, pad_pending_d;
    logic                   loaded_q, loaded_d;
    logic                   err_q, err_d;
    logic                   wait_q, wait_d;
    logic                   bios_wr_q, bios_wr_d;
    logic [BIOS_ADDR_W-1:0] bios_addr_q, bios_addr_d;
    logic [15:0]            bios_din_q, bios_din_d;

    logic                   fifo_clr, fifo_push, fifo_pop;
    logic [15:0]            fifo_push_data, fifo_pop_data;
    logic                   fifo_full, fifo_empty;
    logic [FCW-1:0]         fifo_free, free_next;

    sync_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_sys),
        .rst      (reset),
        .clr      (fifo_clr),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .pop_data (fifo_pop_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (fifo_free)
    );

    assign dl_sel_d = bus.ioctl_download & (bus.ioctl_index == BIOS_INDEX);
    assign dl_rise  = dl_sel_d & ~dl_sel_q;
    assign dl_fall  = ~dl_sel_d & dl_sel_q;

    // Next-state logic. Popping runs in LOAD and DRAIN independently of byte
    // packing, so a push and a pop can share a cycle. The odd trailing byte
    // is padded in DRAIN rather than on the falling edge itself, because the
    // FIFO may be full at that moment and must never be overfilled.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        low_byte_d     = low_byte_q;
        word_cnt_d     = word_cnt_q;
        pad_pending_d  = pad_pending_q;
        loaded_d       = loaded_q;
        err_d          = err_q;
        fifo_clr       = 1'b0;
        fifo_push      = 1'b0;
        fifo_push_data = 16'h0000;

        fifo_pop    = ((state_q == LOAD) || (state_q == DRAIN)) & bus.bios_req & ~fifo_empty;
        bios_wr_d   = fifo_pop;
        bios_addr_d = bios_addr_q;
        bios_din_d  = bios_din_q;
        if (fifo_pop) begin
            bios_addr_d = word_cnt_q[BIOS_ADDR_W-1:0];
            bios_din_d  = fifo_pop_data;
            word_cnt_d  = word_cnt_q + WORD_CNT_W'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (dl_rise) begin
                    state_d       = LOAD;
                    fifo_clr      = 1'b1;
                    byte_cnt_d    = '0;
                    word_cnt_d    = '0;
                    low_byte_d    = 8'h00;
                    pad_pending_d = 1'b0;
                    loaded_d      = 1'b0;
                    err_d         = 1'b0;
                end
            end
            LOAD: begin
                if (dl_fall) begin
                    state_d       = DRAIN;
                    pad_pending_d = byte_cnt_q[0];
                    if (byte_cnt_q < BYTE_LIMIT) begin
                        err_d = 1'b1;
                    end
                end else if (bus.ioctl_wr) begin
                    // Only the address LSB is checked: it must match the lane
                    // the byte counter expects next.
                    if ((byte_cnt_q >= BYTE_LIMIT) || (bus.ioctl_addr[0] != byte_cnt_q[0])) begin
                        err_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        if (byte_cnt_q[0]) begin
                            fifo_push      = 1'b1;
                            fifo_push_data = {bus.ioctl_dout, low_byte_q};
                        end else begin
                            low_byte_d = bus.ioctl_dout;
                        end
                    end
                end
                if (word_cnt_q == WORD_LIMIT) begin
                    loaded_d = 1'b1;
                end
            end
            DRAIN: begin
                if (pad_pending_q && !fifo_full) begin
                    fifo_push      = 1'b1;
                    fifo_push_data = {8'h00, low_byte_q};
                    pad_pending_d  = 1'b0;
                end
                if (word_cnt_q == WORD_LIMIT) begin
                    loaded_d = 1'b1;
                    state_d  = DONE;
                end else if (fifo_empty && !pad_pending_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Backpressure tracks the occupancy the FIFO will have after this
        // edge, so wait is already high whenever only one slot remains.
        free_next = fifo_free - FCW'(fifo_push & ~fifo_full) + FCW'(fifo_pop);
        if (fifo_clr) begin
            free_next = FCW'(FIFO_DEPTH);
        end
        wait_d = (free_next <= FCW'(1));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dl_sel_q      <= 1'b0;
            byte_cnt_q    <= '0;
            low_byte_q    <= 8'h00;
            word_cnt_q    <= '0;
            pad_pending_q <= 1'b0;
            loaded_q      <= 1'b0;
            err_q         <= 1'b0;
            wait_q        <= 1'b0;
            bios_wr_q     <= 1'b0;
            bios_addr_q   <= '0;
            bios_din_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            dl_sel_q      <= dl_sel_d;
            byte_cnt_q    <= byte_cnt_d;
            low_byte_q    <= low_byte_d;
            word_cnt_q    <= word_cnt_d;
            pad_pending_q <= pad_pending_d;
            loaded_q      <= loaded_d;
            err_q         <= err_d;
            wait_q        <= wait_d;
            bios_wr_q     <= bios_wr_d;
            bios_addr_q   <= bios_addr_d;
            bios_din_q    <= bios_din_d;
        end
    end

    assign bus.ioctl_wait  = wait_q;
    assign bus.bios_wr     = bios_wr_q;
    assign bus.bios_addr   = bios_addr_q;
    assign bus.bios_din    = bios_din_q;
    assign bus.bios_loaded = loaded_q;
    assign bus.bios_err    = err_q;

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader
//   Directed bench for bios_loader: reset state, wrong-index download, short
//   odd download, out-of-order download, full image, backpressure with the
//   system stalled, and reset in the middle of a load followed by a reload.
module tb_bios_loader;
    import bios_loader_pkg::*;

    localparam int CAP       = 32768;
    localparam int FULL_B    = 2 * BIOS_WORDS_DEF;
    localparam int FIFO_D    = 16;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    bios_loader_if bus();

    bios_loader #(
        .BIOS_INDEX(8'd0),
        .BIOS_WORDS(BIOS_WORDS_DEF),
        .FIFO_DEPTH(FIFO_D)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int tests_run    = 0;
    int tests_failed = 0;
    int timeouts     = 0;
    int overflow_cnt = 0;

    logic [BIOS_ADDR_W-1:0] cap_addr [CAP];
    logic [15:0]            cap_data [CAP];
    int                     cap_cnt = 0;

    // Capture every word write the system sees.
    always @(negedge clk_sys) begin
        if (bus.bios_wr === 1'b1) begin
            if (cap_cnt < CAP) begin
                cap_addr[cap_cnt] = bus.bios_addr;
                cap_data[cap_cnt] = bus.bios_din;
            end
            cap_cnt++;
        end
    end

    // Any push presented to a full FIFO is an overflow.
    always @(posedge clk_sys) begin
        if (dut.fifo_push === 1'b1 && dut.fifo_full === 1'b1) begin
            overflow_cnt++;
        end
    end

    function automatic logic [7:0] patByte(input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return kk[7:0] ^ kk[15:8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one byte strobe, holding off while the loader asserts wait.
    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
        int guard;
        guard = 0;
        @(negedge clk_sys);
        while (bus.ioctl_wait === 1'b1 && guard < 1000) begin
            bus.ioctl_wr = 1'b0;
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 1000) begin
            timeouts++;
            bus.ioctl_wr = 1'b0;
        end else begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = addr;
            bus.ioctl_dout = data;
        end
    endtask

    task automatic startDownload(input logic [7:0] idx);
        @(negedge clk_sys);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
    endtask

    task automatic endDownload();
        @(negedge clk_sys);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            bus.ioctl_wr = 1'b0;
        end
    endtask

    // Wait (bounded) until n writes have been seen since base, then settle.
    task automatic waitWrites(input int base, input int n, input int limit);
        int cyc;
        cyc = 0;
        while ((cap_cnt - base) < n && cyc < limit) begin
            @(negedge clk_sys);
            cyc++;
        end
        idleCycles(8);
    endtask

    // Count writes that deviate from the byte-pattern image, starting at 0.
    task automatic checkWords(input int base, input int n, output int bad);
        logic [15:0] exp_w;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            exp_w = {patByte(2 * i + 1), patByte(2 * i)};
            if (cap_data[base + i] !== exp_w || cap_addr[base + i] !== BIOS_ADDR_W'(i)) begin
                bad++;
            end
        end
    endtask

    initial begin
        int base;
        int bad;
        int sent;
        int first_wait;
        int cyc;
        logic wait_seen;

        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'h00;
        bus.bios_req       = 1'b1;

        // Reset state
        idleCycles(3);
        checkOutput("rst_flags", {28'd0, bus.ioctl_wait, bus.bios_wr, bus.bios_loaded, bus.bios_err}, 32'd0);
        checkOutput("rst_addr_din", {3'd0, bus.bios_addr, bus.bios_din}, 32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk_sys);
        reset = 1'b0;
        idleCycles(2);

        // Wrong index: strobes must be ignored entirely
        base      = cap_cnt;
        wait_seen = 1'b0;
        startDownload(8'd1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_sys);
            if (bus.ioctl_wait === 1'b1) wait_seen = 1'b1;
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(k);
            bus.ioctl_dout = patByte(k);
        end
        endDownload();
        idleCycles(8);
        checkOutput("wrongidx_writes", 32'(cap_cnt - base), 32'd0);
        checkOutput("wrongidx_wait", {31'd0, wait_seen}, 32'd0);
        checkOutput("wrongidx_state", 32'(dut.state_q), 32'(IDLE));

        // Short odd download: AA BB CC
        base = cap_cnt;
        startDownload(8'd0);
        applyStimulus(25'd0, 8'hAA);
        applyStimulus(25'd1, 8'hBB);
        applyStimulus(25'd2, 8'hCC);
        endDownload();
        waitWrites(base, 2, 200);
        checkOutput("short_count", 32'(cap_cnt - base), 32'd2);
        checkOutput("short_w0", {3'd0, cap_addr[base], cap_data[base]}, {3'd0, 13'd0, 16'hBBAA});
        checkOutput("short_w1", {3'd0, cap_addr[base + 1], cap_data[base + 1]}, {3'd0, 13'd1, 16'h00CC});
        checkOutput("short_status", {30'd0, bus.bios_loaded, bus.bios_err}, 32'b01);

        // Out-of-order: address 0 then 2, second byte dropped
        base = cap_cnt;
        startDownload(8'd0);
        applyStimulus(25'd0, 8'h11);
        applyStimulus(25'd2, 8'h22);
        endDownload();
        waitWrites(base, 1, 200);
        checkOutput("ooo_count", 32'(cap_cnt - base), 32'd1);
        checkOutput("ooo_w0", {16'd0, cap_data[base]}, 32'h0000_0011);
        checkOutput("ooo_status", {30'd0, bus.bios_loaded, bus.bios_err}, 32'b01);

        // Full image with bios_req held high
        base     = cap_cnt;
        timeouts = 0;
        startDownload(8'd0);
        for (int k = 0; k < FULL_B; k++) begin
            applyStimulus(25'(k), patByte(k));
        end
        endDownload();
        waitWrites(base, BIOS_WORDS_DEF, 2000);
        checkWords(base, BIOS_WORDS_DEF, bad);
        checkOutput("full_timeouts", 32'(timeouts), 32'd0);
        checkOutput("full_count", 32'(cap_cnt - base), 32'(BIOS_WORDS_DEF));
        checkOutput("full_words", 32'(bad), 32'd0);
        checkOutput("full_status", {30'd0, bus.bios_loaded, bus.bios_err}, 32'b10);
        checkOutput("full_hold", {3'd0, bus.bios_addr, bus.bios_din},
                    {3'd0, 13'd8191, patByte(FULL_B - 1), patByte(FULL_B - 2)});
        checkOutput("full_state", 32'(dut.state_q), 32'(DONE));

        // Backpressure: system stalled while bytes stream every cycle
        base         = cap_cnt;
        timeouts     = 0;
        overflow_cnt = 0;
        bus.bios_req = 1'b0;
        startDownload(8'd0);
        sent       = 0;
        first_wait = -1;
        cyc        = 0;
        while (first_wait < 0 && cyc < 200) begin
            @(negedge clk_sys);
            cyc++;
            if (bus.ioctl_wait === 1'b1) begin
                first_wait   = sent;
                bus.ioctl_wr = 1'b0;
            end else begin
                bus.ioctl_wr   = 1'b1;
                bus.ioctl_addr = 25'(sent);
                bus.ioctl_dout = patByte(sent);
                sent++;
            end
        end
        checkOutput("bp_wait_rise", {31'd0, (first_wait > 0 && first_wait <= 2 * (FIFO_D - 1))}, 32'd1);
        idleCycles(10);
        checkOutput("bp_wait_held", {31'd0, bus.ioctl_wait}, 32'd1);
        checkOutput("bp_no_writes", 32'(cap_cnt - base), 32'd0);
        bus.bios_req = 1'b1;
        while (sent < 64) begin
            applyStimulus(25'(sent), patByte(sent));
            sent++;
        end
        endDownload();
        waitWrites(base, 32, 500);
        checkWords(base, 32, bad);
        checkOutput("bp_timeouts", 32'(timeouts), 32'd0);
        checkOutput("bp_count", 32'(cap_cnt - base), 32'd32);
        checkOutput("bp_words", 32'(bad), 32'd0);
        checkOutput("bp_overflow", 32'(overflow_cnt), 32'd0);
        checkOutput("bp_status", {30'd0, bus.bios_loaded, bus.bios_err}, 32'b01);

        // Reset at word 4000, then a fresh full load
        base = cap_cnt;
        startDownload(8'd0);
        for (int k = 0; k < 8000; k++) begin
            applyStimulus(25'(k), patByte(k));
        end
        idleCycles(8);
        checkOutput("mid_count", 32'(cap_cnt - base), 32'd4000);
        checkOutput("mid_state", 32'(dut.state_q), 32'(LOAD));
        @(negedge clk_sys);
        reset              = 1'b1;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        #1;
        checkOutput("mid_rst_flags", {28'd0, bus.ioctl_wait, bus.bios_wr, bus.bios_loaded, bus.bios_err}, 32'd0);
        checkOutput("mid_rst_addr_din", {3'd0, bus.bios_addr, bus.bios_din}, 32'd0);
        checkOutput("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        idleCycles(3);
        reset = 1'b0;
        idleCycles(2);

        base     = cap_cnt;
        timeouts = 0;
        startDownload(8'd0);
        for (int k = 0; k < FULL_B; k++) begin
            applyStimulus(25'(k), patByte(k));
        end
        endDownload();
        waitWrites(base, BIOS_WORDS_DEF, 2000);
        checkWords(base, BIOS_WORDS_DEF, bad);
        checkOutput("reload_timeouts", 32'(timeouts), 32'd0);
        checkOutput("reload_first_addr", {19'd0, cap_addr[base]}, 32'd0);
        checkOutput("reload_count", 32'(cap_cnt - base), 32'(BIOS_WORDS_DEF));
        checkOutput("reload_words", 32'(bad), 32'd0);
        checkOutput("reload_status", {30'd0, bus.bios_loaded, bus.bios_err}, 32'b10);
        checkOutput("overflow_total", 32'(overflow_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
